// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Builds a 3x3 neighbourhood from a raster-order 8-bit pixel stream and
// hands one window per interior pixel to the Sobel edge stage.
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   in_valid       - pix_in is accepted on this edge (no backpressure)
//   sof            - with in_valid: this pixel is (row 0, col 0)
//   pix_in[7:0]    - unsigned pixel
//   w0..w8[7:0]    - window, top row w0..w2, middle w3..w5 (w4 centre),
//                    bottom w6..w8
//   win_valid      - one-cycle strobe qualifying w0..w8 (Sobel en)
//   frame_done     - pulses together with the last window of a frame
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       sof,
  input  logic [7:0] pix_in,
  output logic [7:0] w0,
  output logic [7:0] w1,
  output logic [7:0] w2,
  output logic [7:0] w3,
  output logic [7:0] w4,
  output logic [7:0] w5,
  output logic [7:0] w6,
  output logic [7:0] w7,
  output logic [7:0] w8,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  // Line buffers: lb1 holds row r-2, lb0 holds row r-1. Not reset; rows 0
  // and 1 of each frame refill them before any window is flagged.
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];

  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;

  // Position of the pixel being accepted; sof forces (0,0).
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    lb0_rd  = lb0[cur_col];
    lb1_rd  = lb1[cur_col];
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      // Columns 0/1 would straddle a line wrap, rows 0/1 would use stale
      // line-buffer data: neither is flagged.
      win_valid_d  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

      // Shift the window left by one column and load the new right column.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Read-before-write: lb0_rd/lb1_rd above see the old contents this cycle.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pix_in;
    end
  end

  assign w0         = win_q[0];
  assign w1         = win_q[1];
  assign w2         = win_q[2];
  assign w3         = win_q[3];
  assign w4         = win_q[4];
  assign w5         = win_q[5];
  assign w6         = win_q[6];
  assign w7         = win_q[7];
  assign w8         = win_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen: a 4x4 instance (basic, gaps, back-to-back)
// and a 5x5 instance (mid-frame sof, async reset, Sobel gradient image).
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, iv0, iv1, sof0, sof1;
  logic [7:0] pix0, pix1;
  logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic       wv0, fd0, wv1, fd1;
  logic [71:0] win0, win1;

  assign win0 = {a0, a1, a2, a3, a4, a5, a6, a7, a8};
  assign win1 = {b0, b1, b2, b3, b4, b5, b6, b7, b8};

  sobel_window_gen #(.IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .sof(sof0), .pix_in(pix0),
    .w0(a0), .w1(a1), .w2(a2), .w3(a3), .w4(a4), .w5(a5), .w6(a6), .w7(a7), .w8(a8),
    .win_valid(wv0), .frame_done(fd0)
  );

  sobel_window_gen #(.IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .sof(sof1), .pix_in(pix1),
    .w0(b0), .w1(b1), .w2(b2), .w3(b3), .w4(b4), .w5(b5), .w6(b6), .w7(b7), .w8(b8),
    .win_valid(wv1), .frame_done(fd1)
  );

  typedef struct {
    logic [71:0] win;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   gx_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   gx_en = 1'b0;
  bit   stab_en = 1'b0;
  bit   acc0_s = 1'b0;
  logic [71:0] prev_win0 = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc0_s = iv0;

  function automatic logic [7:0] pixf(input int mode, input int base, input int r, input int c);
    if (mode == 1) return (c < 2) ? 8'd0 : 8'd100;
    return 8'(base + 16 * r + c);
  endfunction

  // Drive one pixel; push the expected window (due the cycle after the edge).
  task automatic accept(input int d, input int mode, input int base, input int r,
                        input int c, input int W, input int H, input bit s);
    exp_t e;
    logic [7:0] p;
    p = pixf(mode, base, r, c);
    if (d == 0) begin iv0 = 1'b1; sof0 = s; pix0 = p; end
    else        begin iv1 = 1'b1; sof1 = s; pix1 = p; end
    @(posedge clk); #1;
    if (d == 0) begin iv0 = 1'b0; sof0 = 1'b0; end
    else        begin iv1 = 1'b0; sof1 = 1'b0; end
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++)
        e.win[71-8*k -: 8] = pixf(mode, base, r - 2 + k / 3, c - 2 + k % 3);
      e.fd  = (r == H - 1) && (c == W - 1);
      e.cyc = cyc;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic gap(input int d);
    if (d == 0) begin iv0 = 1'b0; pix0 = 8'($urandom); sof0 = 1'($urandom); end
    else        begin iv1 = 1'b0; pix1 = 8'($urandom); sof1 = 1'($urandom); end
    @(posedge clk); #1;
    if (d == 0) sof0 = 1'b0; else sof1 = 1'b0;
  endtask

  task automatic frame(input int d, input int mode, input int base, input int W,
                       input int H, input int n, input bit gaps, input bit sof_first);
    int k;
    k = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (k < n) begin
          accept(d, mode, base, r, c, W, H, sof_first && (k == 0));
          if (gaps) gap(d);
        end
        k++;
      end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard: one line per window seen.
  always @(negedge clk) begin
    exp_t e;
    int gx;
    if (wv0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL u4_unexpected_win actual=%h required=none cyc=%0d", win0, cyc);
      end else begin
        e = q0.pop_front();
        if (win0 !== e.win || fd0 !== e.fd || cyc != e.cyc) begin
          errors++;
          $display("FAIL u4_win actual=%h fd=%b cyc=%0d required=%h fd=%b cyc=%0d",
                   win0, fd0, cyc, e.win, e.fd, e.cyc);
        end else
          $display("u4 window %h fd=%b cyc=%0d ok", win0, fd0, cyc);
      end
    end else begin
      checks++;
      if (fd0 !== 1'b0) begin
        errors++;
        $display("FAIL u4_fd_without_win actual=%b required=0 cyc=%0d", fd0, cyc);
      end
    end
    if (stab_en && !acc0_s) begin
      checks++;
      if (win0 !== prev_win0) begin
        errors++;
        $display("FAIL u4_w_stable_in_gap actual=%h required=%h", win0, prev_win0);
      end
    end
    prev_win0 = win0;

    if (wv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u5_unexpected_win actual=%h required=none cyc=%0d", win1, cyc);
      end else begin
        e = q1.pop_front();
        if (win1 !== e.win || fd1 !== e.fd || cyc != e.cyc) begin
          errors++;
          $display("FAIL u5_win actual=%h fd=%b cyc=%0d required=%h fd=%b cyc=%0d",
                   win1, fd1, cyc, e.win, e.fd, e.cyc);
        end else
          $display("u5 window %h fd=%b cyc=%0d ok", win1, fd1, cyc);
      end
      if (gx_en) begin
        gx = (int'(b2) + 2 * int'(b5) + int'(b8)) - (int'(b0) + 2 * int'(b3) + int'(b6));
        if (gx < 0) gx = -gx;
        if (gx > 255) gx = 255;
        gx_q.push_back(gx);
      end
    end else begin
      checks++;
      if (fd1 !== 1'b0) begin
        errors++;
        $display("FAIL u5_fd_without_win actual=%b required=0 cyc=%0d", fd1, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0; sof0 = 1'b0; sof1 = 1'b0; pix0 = '0; pix1 = '0;
    #1;
    check("u4_reset_outputs", int'(|{win0, wv0, fd0}), 0);
    check("u5_reset_outputs", int'(|{win1, wv1, fd1}), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;
    stab_en = 1'b1;

    // 4x4: basic frame, gapped frame, then two back-to-back frames.
    frame(0, 0, 8'h00, 4, 4, 16, 1'b0, 1'b1);
    frame(0, 0, 8'h00, 4, 4, 16, 1'b1, 1'b0);
    frame(0, 0, 8'h00, 4, 4, 16, 1'b0, 1'b0);
    frame(0, 0, 8'h80, 4, 4, 16, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("u4_queue_drained", q0.size(), 0);

    // 5x5: aborted frame up to (2,0), then sof at (2,1) starts a full frame.
    frame(1, 0, 8'h40, 5, 5, 11, 1'b0, 1'b1);
    frame(1, 0, 8'h00, 5, 5, 25, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("u5_sof_queue_drained", q1.size(), 0);

    // Async reset while a row-3 window is presented.
    frame(1, 0, 8'h20, 5, 5, 18, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("u5_win_valid_before_rst", int'(wv1), 1);
    rst1 = 1'b1;
    #1;
    check("u5_outputs_after_async_rst", int'(|{win1, wv1, fd1}), 0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    frame(1, 0, 8'h30, 5, 5, 25, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("u5_rst_queue_drained", q1.size(), 0);

    // Sobel image: left two columns 0, rest 100.
    gx_en = 1'b1;
    frame(1, 1, 0, 5, 5, 25, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    gx_en = 1'b0;
    check("u5_gx_window_count", gx_q.size(), 9);
    if (gx_q.size() == 9) begin
      check("u5_gx_centre_1_1", gx_q[0], 255);
      check("u5_gx_centre_1_3", gx_q[2], 0);
      check("u5_gx_centre_2_3", gx_q[5], 0);
      check("u5_gx_centre_3_3", gx_q[8], 0);
    end
    check("u5_final_queue_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Upstream feeder for the Sobel edge stage. It accepts a raster-order 8-bit pixel stream and holds the previous two image rows in line buffers. It emits one 3x3 neighbourhood per interior pixel as nine parallel bytes plus a one-cycle valid strobe, which drive the Sobel stage's `i0..i8` and `en` inputs directly. Border pixels do not produce windows; the Sobel stage therefore only ever sees fully populated neighbourhoods.

## Interface
- `IMG_W`, 128, image width in pixels (>= 3)
- `IMG_H`, 128, image height in lines (>= 3)
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  `pix_in` is valid this cycle; no backpressure
- `sof`  in  1  start of frame; qualified by `in_valid`; this pixel is (row 0, col 0)
- `pix_in`  in  8  pixel, unsigned
- `w0`..`w8`  out  8 each  window
  - `w0 w1 w2` = top row, left to right
  - `w3 w4 w5` = middle row (`w4` = centre)
  - `w6 w7 w8` = bottom row
- `win_valid`  out  1  window outputs valid this cycle; connect to Sobel `en`
- `frame_done`  out  1  one-cycle pulse coinciding with the last window of a frame

## Operation
- A pixel is accepted on a rising edge with `in_valid=1`. Nothing changes on cycles with `in_valid=0`, except `win_valid` and `frame_done`, which drop to 0.
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the pixel being accepted.
  - After accepting col=IMG_W-1, `col` goes to 0 and `row` increments.
  - After accepting (IMG_H-1, IMG_W-1), both go to 0.
- `sof` with `in_valid`: the accepted pixel is treated as (0,0) regardless of the counters. The next pixel is (0,1). This resynchronises a frame mid-stream.
- Line buffers: two IMG_W x 8 arrays.
  - LB1 holds row r-2; LB0 holds row r-1.
  - On accepting pixel p at column c: read LB1[c] and LB0[c], then write LB1[c] <= LB0[c] and LB0[c] <= p.
- Window shift on every accept:
  - Left column <= middle column; middle column <= right column.
  - New right column: `w2` <= LB1[c], `w5` <= LB0[c], `w8` <= p.
- `win_valid` is registered. It is set to 1 on the accept edge when the accepted pixel has row >= 2 and col >= 2; otherwise it is set to 0.
  - The window then presented is centred at (row-1, col-1).
  - Windows that straddle a line wrap (col 0 or 1) are never flagged.
- `frame_done` is registered. It is 1 for the cycle after accepting (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Line buffer contents are not reset. Rows 0 and 1 of every frame overwrite them before any window is flagged, so stale data never reaches a valid window.
- Line buffers may be registers or inferred single-port RAM with read-before-write semantics.

## Timing
- Reset values: `w0`..`w8` = 0, `win_valid` = 0, `frame_done` = 0, `col` = 0, `row` = 0.
- Latency: the window that completes with pixel (r,c) appears on the cycle after that pixel's accept edge, for exactly one cycle of `win_valid`.
- `w*` holds its value on gap cycles. Only `win_valid` qualifies it.
- Throughput: one window per cycle at full input rate. Gaps in `in_valid` pass straight through to `win_valid`.
- Boundary conditions:
  - `sof` at (0,0) is redundant and harmless.
  - `sof` mid-frame truncates the old frame with no `frame_done` pulse. The window for the pixel accepted on the `sof` edge is not flagged.
  - Reset mid-frame clears the counters and outputs on the next evaluation; the following accepted pixel is (0,0).
  - If `rst` is asserted while a window is valid, `win_valid` falls immediately (asynchronously).
  - Back-to-back frames need no idle cycle: pixel (0,0) of frame N+1 may follow (H-1,W-1) of frame N on the next cycle.

## Test plan
- **Basic frame.**
  - Stimulus: IMG_W=4, IMG_H=4, continuous `in_valid`, pixel = 16*row+col.
  - Response: exactly 4 windows.
  - First window is 0x00,01,02,10,11,12,20,21,22, one cycle after pixel (2,2) is accepted.
  - Last window is 0x11,12,13,21,22,23,31,32,33, with `frame_done`=1 in the same cycle.
- **Input gaps.**
  - Stimulus: same frame with `in_valid` toggled 1,0,1,0.
  - Response: the same 4 windows in the same order; `win_valid` never asserted in a gap cycle; `w*` stable through gaps.
- **Back-to-back frames.**
  - Stimulus: two 4x4 frames, the second with pixel = 0x80+16*row+col, no idle cycle between them.
  - Response: 8 windows total. The first window of frame 2 is 0x80,81,82,90,91,92,A0,A1,A2 with no frame-1 data. Two `frame_done` pulses.
- **Mid-frame sof.**
  - Stimulus: assert `sof` at (2,1) of a 5x5 frame, then send a full 5x5 frame.
  - Response: no `frame_done` for the aborted frame; 9 windows from the new frame, all correct.
- **Async reset.**
  - Stimulus: assert `rst` for 1 cycle while `win_valid`=1 in row 3 of a 5x5 frame, then restart the frame.
  - Response: all outputs are 0 immediately; the next accepted pixel is treated as (0,0); 9 correct windows follow.
- **Sobel integration.**
  - Stimulus: feed the Sobel stage from this block with a 5x5 image, left 2 columns = 0 and rest = 100.
  - Response: the horizontal-gradient output for the window centred at (1,1) is 255 (saturated); windows centred in column 3 give 0.
